// File: rtl/cache_pkg.sv
// Shared constants, region codes and address-field helpers for the two-bank
// direct-mapped cache front end.
package cache_pkg;

    localparam logic [3:0] REGION_WT = 4'h0;
    localparam logic [3:0] REGION_WB = 4'h1;

    localparam int LINES     = 16;
    localparam int INDEX_W   = 4;
    localparam int TAG_W     = 22;
    localparam int MEM_WORDS = 256;
    localparam int MEM_AW    = 8;

    typedef enum logic [1:0] {
        SEL_WT     = 2'd0,
        SEL_WB     = 2'd1,
        SEL_BYPASS = 2'd2
    } region_sel_e;

    function automatic logic [3:0] addr_region(input logic [31:0] a);
        return a[31:28];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [31:0] a);
        return a[5:2];
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
        return a[27:6];
    endfunction

    function automatic logic [MEM_AW-1:0] addr_mem_idx(input logic [31:0] a);
        return a[9:2];
    endfunction

endpackage

// File: rtl/dm_cache_bank.sv
// One direct-mapped bank plus its region's backing memory. Lookup results are
// combinational; all cache and memory state updates on the access edge.
module dm_cache_bank
    import cache_pkg::*;
#(
    parameter bit WRITE_BACK = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_i,
    input  logic               we_i,
    input  logic [TAG_W-1:0]   tag_i,
    input  logic [INDEX_W-1:0] index_i,
    input  logic [MEM_AW-1:0]  mem_idx_i,
    input  logic [31:0]        wdata_i,
    output logic               hit_o,
    output logic [31:0]        rdata_o
);

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] dirty_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];
    logic [31:0]      mem_q  [MEM_WORDS];

    logic              victim_wb;
    logic [MEM_AW-1:0] victim_mem_idx;
    logic [31:0]       fill_data;
    logic              dirty_d;

    always_comb begin
        hit_o          = valid_q[index_i] && (tag_q[index_i] == tag_i);
        victim_wb      = WRITE_BACK && !hit_o && valid_q[index_i] && dirty_q[index_i];
        victim_mem_idx = {tag_q[index_i][MEM_AW-INDEX_W-1:0], index_i};
        // The victim write lands before the fill read, so forward it when both
        // resolve to the same memory word (upper tag bits alias).
        if (victim_wb && (victim_mem_idx == mem_idx_i)) begin
            fill_data = data_q[index_i];
        end else begin
            fill_data = mem_q[mem_idx_i];
        end
        if (we_i) begin
            rdata_o = wdata_i;
        end else if (hit_o) begin
            rdata_o = data_q[index_i];
        end else begin
            rdata_o = fill_data;
        end
        if (!WRITE_BACK) begin
            dirty_d = 1'b0;
        end else if (we_i) begin
            dirty_d = 1'b1;
        end else if (hit_o) begin
            dirty_d = dirty_q[index_i];
        end else begin
            dirty_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (req_i) begin
            valid_q[index_i] <= 1'b1;
            dirty_q[index_i] <= dirty_d;
        end
    end

    // Tag, data and memory arrays carry no reset; an access during reset is dropped.
    always_ff @(posedge clk) begin
        if (req_i && !rst) begin
            tag_q[index_i]  <= tag_i;
            data_q[index_i] <= rdata_o;
            if (!WRITE_BACK && we_i) begin
                mem_q[mem_idx_i] <= wdata_i;
            end
            if (victim_wb) begin
                mem_q[victim_mem_idx] <= data_q[index_i];
            end
        end
    end

endmodule

// File: rtl/top_level_cache.sv
// Region decode in front of a write-through bank (region 0) and a write-back
// bank (region 1); other regions bypass with zero results.
module top_level_cache
    import cache_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        is_write,
    input  logic [31:0] write_data,
    output logic        hit,
    output logic [31:0] read_data
);

    region_sel_e sel;
    logic        wt_hit;
    logic        wb_hit;
    logic [31:0] wt_rdata;
    logic [31:0] wb_rdata;
    logic        hit_d;
    logic        hit_q;
    logic [31:0] read_data_d;
    logic [31:0] read_data_q;
    logic [1:0]  unused_addr_bits;

    assign unused_addr_bits = address[1:0];

    always_comb begin
        sel = SEL_BYPASS;
        if (addr_region(address) == REGION_WT) begin
            sel = SEL_WT;
        end else if (addr_region(address) == REGION_WB) begin
            sel = SEL_WB;
        end
    end

    dm_cache_bank #(.WRITE_BACK(1'b0)) u_wt (
        .clk      (clk),
        .rst      (reset),
        .req_i    (sel == SEL_WT),
        .we_i     (is_write),
        .tag_i    (addr_tag(address)),
        .index_i  (addr_index(address)),
        .mem_idx_i(addr_mem_idx(address)),
        .wdata_i  (write_data),
        .hit_o    (wt_hit),
        .rdata_o  (wt_rdata)
    );

    dm_cache_bank #(.WRITE_BACK(1'b1)) u_wb (
        .clk      (clk),
        .rst      (reset),
        .req_i    (sel == SEL_WB),
        .we_i     (is_write),
        .tag_i    (addr_tag(address)),
        .index_i  (addr_index(address)),
        .mem_idx_i(addr_mem_idx(address)),
        .wdata_i  (write_data),
        .hit_o    (wb_hit),
        .rdata_o  (wb_rdata)
    );

    always_comb begin
        hit_d       = 1'b0;
        read_data_d = '0;
        case (sel)
            SEL_WT: begin
                hit_d       = wt_hit;
                read_data_d = wt_rdata;
            end
            SEL_WB: begin
                hit_d       = wb_hit;
                read_data_d = wb_rdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_q       <= 1'b0;
            read_data_q <= '0;
        end else begin
            hit_q       <= hit_d;
            read_data_q <= read_data_d;
        end
    end

    assign hit       = hit_q;
    assign read_data = read_data_q;

endmodule

// File: tb/tb_top_level_cache.sv
// Directed bench: a line/memory model predicts every access, plus hand-computed
// literals from the cache-policy walkthrough.
module tb_top_level_cache;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic        is_write;
    logic [31:0] write_data;
    logic        hit;
    logic [31:0] read_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit        h;
        bit [31:0] d;
        bit [31:0] a;
    } exp_t;
    exp_t exp_q[$];

    // Model: per-region memory and per-bank line state.
    bit [31:0] m_mem   [2][256];
    bit        m_valid [2][16];
    bit        m_dirty [2][16];
    bit [21:0] m_tag   [2][16];
    bit [31:0] m_data  [2][16];

    top_level_cache dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .is_write  (is_write),
        .write_data(write_data),
        .hit       (hit),
        .read_data (read_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[b][i] = 1'b0;
                m_dirty[b][i] = 1'b0;
            end
        end
    endtask

    task automatic model_access(input bit [31:0] a, input bit we, input bit [31:0] wd,
                                output bit h, output bit [31:0] d);
        int b, idx, mi;
        bit [21:0] tg;
        h = 1'b0;
        d = 32'h0;
        if (a[31:28] > 4'h1) return;
        b   = int'(a[31:28]);
        idx = int'(a[5:2]);
        mi  = int'(a[9:2]);
        tg  = a[27:6];
        h   = m_valid[b][idx] && (m_tag[b][idx] == tg);
        if (b == 1 && !h && m_valid[1][idx] && m_dirty[1][idx])
            m_mem[1][{m_tag[1][idx][3:0], a[5:2]}] = m_data[1][idx];
        if (we) begin
            d = wd;
            if (b == 0) m_mem[0][mi] = wd;
            m_dirty[b][idx] = (b == 1);
        end else if (h) begin
            d = m_data[b][idx];
        end else begin
            d = m_mem[b][mi];
            m_dirty[b][idx] = 1'b0;
        end
        m_valid[b][idx] = 1'b1;
        m_tag[b][idx]   = tg;
        m_data[b][idx]  = d;
    endtask

    // Compare process: one expectation per sampled access.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check($sformatf("model_hit@%h", e.a), {31'b0, hit}, {31'b0, e.h});
            check($sformatf("model_data@%h", e.a), read_data, e.d);
            $display("access addr=%h hit=%0b data=%h (model hit=%0b data=%h)",
                     e.a, hit, read_data, e.h, e.d);
        end
    end

    // Entered at posedge+2; returns at the following posedge+2.
    task automatic access(input bit [31:0] a, input bit we, input bit [31:0] wd,
                          input bit lit, input bit lit_h, input bit [31:0] lit_d);
        exp_t e;
        bit h;
        bit [31:0] d;
        address    = a;
        is_write   = we;
        write_data = wd;
        model_access(a, we, wd, h, d);
        e.h = h;
        e.d = d;
        e.a = a;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (lit) begin
            check($sformatf("lit_hit@%h", a), {31'b0, hit}, {31'b0, lit_h});
            check($sformatf("lit_data@%h", a), read_data, lit_d);
        end
        #1;
    endtask

    initial begin
        model_reset();
        reset      = 1'b1;
        address    = 32'h0;
        is_write   = 1'b0;
        write_data = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_hit", {31'b0, hit}, 32'h0);
        check("reset_data", read_data, 32'h0);
        #1;
        reset = 1'b0;

        access(32'h0000_0000, 1, 32'hAAAA_0000, 1, 0, 32'hAAAA_0000);
        check("wt_mem0", dut.u_wt.mem_q[0], 32'hAAAA_0000);
        access(32'h0000_0000, 0, 32'h0,         1, 1, 32'hAAAA_0000);
        access(32'h0000_0010, 1, 32'hBBBB_0000, 1, 0, 32'hBBBB_0000);
        access(32'h0000_0010, 0, 32'h0,         1, 1, 32'hBBBB_0000);
        access(32'h0000_0000, 0, 32'h0,         1, 1, 32'hAAAA_0000);

        access(32'h1000_0000, 1, 32'h1111_0000, 1, 0, 32'h1111_0000);
        check("wb_mem0_clean", dut.u_wb.mem_q[0], 32'h0);
        access(32'h1000_0000, 0, 32'h0,         1, 1, 32'h1111_0000);
        access(32'h1000_0040, 1, 32'h2222_0000, 1, 0, 32'h2222_0000);
        check("wb_mem0_evict", dut.u_wb.mem_q[0], 32'h1111_0000);
        access(32'h1000_0040, 0, 32'h0,         1, 1, 32'h2222_0000);
        access(32'h1000_0000, 0, 32'h0,         1, 0, 32'h1111_0000);
        check("wb_mem16_evict", dut.u_wb.mem_q[16], 32'h2222_0000);

        access(32'h2000_0000, 1, 32'h5555_5555, 1, 0, 32'h0);
        access(32'hF000_0010, 0, 32'h0,         1, 0, 32'h0);
        access(32'h0000_0003, 0, 32'h0,         1, 1, 32'hAAAA_0000);

        // Victim and requested line share memory word 0 (tags differ above bit 3).
        access(32'h1000_0400, 1, 32'h3333_0000, 1, 0, 32'h3333_0000);
        access(32'h1000_0000, 0, 32'h0,         1, 0, 32'h3333_0000);
        check("wb_mem0_alias", dut.u_wb.mem_q[0], 32'h3333_0000);

        access(32'h0000_0100, 1, 32'hC0C0_0000, 1, 0, 32'hC0C0_0000);
        access(32'h0000_0000, 0, 32'h0,         1, 0, 32'hAAAA_0000);

        // Reset mid-sequence; the access presented while reset is high is dropped.
        address    = 32'h0000_0000;
        is_write   = 1'b1;
        write_data = 32'hDEAD_BEEF;
        reset      = 1'b1;
        model_reset();
        #1;
        check("midreset_hit", {31'b0, hit}, 32'h0);
        check("midreset_data", read_data, 32'h0);
        @(posedge clk);
        #1;
        check("held_reset_data", read_data, 32'h0);
        #1;
        reset = 1'b0;

        access(32'h0000_0000, 0, 32'h0,         1, 0, 32'hAAAA_0000);
        access(32'h1000_0000, 0, 32'h0,         1, 0, 32'h3333_0000);
        access(32'h1000_0000, 1, 32'h4444_0000, 1, 1, 32'h4444_0000);
        access(32'h1000_0000, 1, 32'h4545_0000, 1, 1, 32'h4545_0000);
        access(32'h1000_0040, 0, 32'h0,         1, 0, 32'h2222_0000);
        check("wb_mem0_final", dut.u_wb.mem_q[0], 32'h4545_0000);

        @(posedge clk);
        #2;
        check("exp_queue_drained", exp_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
